// File: rtl/pma_region_checker.sv
// Runtime-programmable PMA region checker: NrRules attribute regions plus a one-stage lookup pipeline.
// Define PMA_VIOLATION_LOG_EN to add a first-fault violation log directly after the rule table.
module pma_region_checker #(
    parameter int unsigned NrRules       = 8,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned CfgAddrWidth  = 12,
    parameter bit          DefaultCached = 1'b0,
    parameter bit          DefaultExec   = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_req_i,
    input  logic                    cfg_we_i,
    input  logic [CfgAddrWidth-1:0] cfg_addr_i,
    input  logic [AddrWidth-1:0]    cfg_wdata_i,
    output logic                    cfg_gnt_o,
    output logic                    cfg_rvalid_o,
    output logic [AddrWidth-1:0]    cfg_rdata_o,
    output logic                    cfg_err_o,
    input  logic                    lk_valid_i,
    output logic                    lk_ready_o,
    input  logic [AddrWidth-1:0]    lk_addr_i,
    input  logic [1:0]              lk_type_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_hit_o,
    output logic [3:0]              rsp_rule_o,
    output logic                    rsp_cached_o,
    output logic                    rsp_nonidem_o,
    output logic                    rsp_fault_o
);

    localparam int unsigned RuleBytes = NrRules * 32;

    logic [AddrWidth-1:0] ruleBase    [NrRules];
    logic [AddrWidth-1:0] ruleLen     [NrRules];
    logic                 ruleNonidem [NrRules];
    logic                 ruleCached  [NrRules];
    logic                 ruleExec    [NrRules];
    logic                 ruleLock    [NrRules];

    logic [31:0]          cfgAddr;
    logic [3:0]           cfgRule;
    logic [1:0]           cfgOffset;
    logic                 cfgInRules;
    logic                 cfgLogHit;
    logic                 cfgLocked;
    logic                 cfgErr;
    logic                 cfgWrite;
    logic [AddrWidth-1:0] cfgReadVal;

    logic                 lkAccept;
    logic                 lkHit;
    logic [3:0]           lkRule;
    logic                 lkCached;
    logic                 lkNonidem;
    logic                 lkExec;
    logic                 lkFault;

`ifdef PMA_VIOLATION_LOG_EN
    logic                 logValid;
    logic [AddrWidth-1:0] logAddr;
    logic [1:0]           logType;
    logic [3:0]           logRule;
`endif

    assign cfg_gnt_o = cfg_req_i;
    assign cfgWrite  = cfg_req_i && cfg_we_i && !cfgErr;

    // Decode the config byte address; out-of-range rule indices are harmless because cfgErr masks them.
    always_comb begin
        cfgAddr    = 32'(cfg_addr_i);
        cfgRule    = cfgAddr[8:5];
        cfgOffset  = cfgAddr[4:3];
        cfgInRules = cfgAddr < RuleBytes;
        cfgLocked  = 1'b0;
        cfgReadVal = '0;
        for (int i = 0; i < NrRules; i++) begin
            if (4'(i) == cfgRule) begin
                cfgLocked = ruleLock[i];
                case (cfgOffset)
                    2'd0:    cfgReadVal = ruleBase[i];
                    2'd1:    cfgReadVal = ruleLen[i];
                    2'd2:    cfgReadVal = AddrWidth'({ruleLock[i], 28'd0, ruleExec[i],
                                                      ruleCached[i], ruleNonidem[i]});
                    default: cfgReadVal = '0;
                endcase
            end
        end
`ifdef PMA_VIOLATION_LOG_EN
        cfgLogHit = (cfgAddr >= RuleBytes) && (cfgAddr < RuleBytes + 16);
        if (cfgLogHit) begin
            cfgReadVal = cfgAddr[3] ? AddrWidth'({logValid, 25'd0, logType, logRule}) : logAddr;
        end
`else
        cfgLogHit = 1'b0;
`endif
        cfgErr = (cfgAddr[2:0] != 3'd0) || !(cfgInRules || cfgLogHit) ||
                 (cfgInRules && ((cfgOffset == 2'd3) || (cfg_we_i && cfgLocked)));
    end

    // Rule table; a set lock bit freezes the whole rule until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrRules; i++) begin
                ruleBase[i]    <= '0;
                ruleLen[i]     <= '0;
                ruleNonidem[i] <= 1'b0;
                ruleCached[i]  <= 1'b0;
                ruleExec[i]    <= 1'b0;
                ruleLock[i]    <= 1'b0;
            end
        end else if (cfgWrite && cfgInRules) begin
            for (int i = 0; i < NrRules; i++) begin
                if (4'(i) == cfgRule) begin
                    case (cfgOffset)
                        2'd0: ruleBase[i] <= cfg_wdata_i;
                        2'd1: ruleLen[i]  <= cfg_wdata_i;
                        2'd2: begin
                            ruleNonidem[i] <= cfg_wdata_i[0];
                            ruleCached[i]  <= cfg_wdata_i[1];
                            ruleExec[i]    <= cfg_wdata_i[2];
                            ruleLock[i]    <= cfg_wdata_i[31];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_rvalid_o <= 1'b0;
            cfg_err_o    <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_err_o    <= cfg_req_i && cfgErr;
            cfg_rdata_o  <= (cfg_req_i && !cfg_we_i && !cfgErr) ? cfgReadVal : '0;
        end
    end

    // Scanning from the top index down lets the lowest matching rule overwrite the others.
    always_comb begin
        lkHit     = 1'b0;
        lkRule    = 4'd0;
        lkCached  = DefaultCached;
        lkNonidem = 1'b0;
        lkExec    = DefaultExec;
        for (int i = NrRules - 1; i >= 0; i--) begin
            if ((ruleLen[i] != '0) && (lk_addr_i >= ruleBase[i]) &&
                ((lk_addr_i - ruleBase[i]) < ruleLen[i])) begin
                lkHit     = 1'b1;
                lkRule    = 4'(i);
                lkCached  = ruleCached[i];
                lkNonidem = ruleNonidem[i];
                lkExec    = ruleExec[i];
            end
        end
        lkFault = ((lk_type_i == 2'd2) && (!lkExec || lkNonidem)) || (lk_type_i == 2'd3);
    end

    assign lk_ready_o = !rsp_valid_o || rsp_ready_i;
    assign lkAccept   = lk_valid_i && lk_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_o   <= 1'b0;
            rsp_hit_o     <= 1'b0;
            rsp_rule_o    <= 4'd0;
            rsp_cached_o  <= 1'b0;
            rsp_nonidem_o <= 1'b0;
            rsp_fault_o   <= 1'b0;
        end else if (lkAccept) begin
            rsp_valid_o   <= 1'b1;
            rsp_hit_o     <= lkHit;
            rsp_rule_o    <= lkRule;
            rsp_cached_o  <= lkCached && !lkFault;
            rsp_nonidem_o <= lkNonidem;
            rsp_fault_o   <= lkFault;
        end else if (rsp_ready_i) begin
            rsp_valid_o   <= 1'b0;
        end
    end

`ifdef PMA_VIOLATION_LOG_EN
    // Capture only while the log is empty, so the first fault sticks until software clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            logValid <= 1'b0;
            logAddr  <= '0;
            logType  <= 2'd0;
            logRule  <= 4'd0;
        end else if (lkAccept && lkFault && !logValid) begin
            logValid <= 1'b1;
            logAddr  <= lk_addr_i;
            logType  <= lk_type_i;
            logRule  <= lkRule;
        end else if (cfgWrite && cfgLogHit && cfgAddr[3]) begin
            logValid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pma_region_checker.sv
// Scoreboard bench for pma_region_checker: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_pma_region_checker;

    localparam logic [1:0] Load  = 2'd0;
    localparam logic [1:0] Store = 2'd1;
    localparam logic [1:0] Fetch = 2'd2;
    localparam logic [1:0] Rsvd  = 2'd3;

    typedef struct {
        string      name;
        logic       hit;
        logic [3:0] rule;
        logic       cached;
        logic       nonidem;
        logic       fault;
    } LkExp;

    typedef struct {
        string       name;
        logic        err;
        logic [63:0] rdata;
    } CfgExp;

    logic        clk = 1'b0;
    logic        rstN;
    logic        cfgReq, cfgWe;
    logic [11:0] cfgAddr;
    logic [63:0] cfgWdata;
    logic        lkValid, rspReady;
    logic [63:0] lkAddr;
    logic [1:0]  lkType;

    logic        cfgGnt, cfgRvalid, cfgErr;
    logic [63:0] cfgRdata;
    logic        lkReady, rspValid, rspHit, rspCached, rspNonidem, rspFault;
    logic [3:0]  rspRule;

    LkExp  lkQ[$];
    CfgExp cfgQ[$];
    int    testsRun    = 0;
    int    testsFailed = 0;

    pma_region_checker dut (
        .clk_i        (clk),
        .rst_ni       (rstN),
        .cfg_req_i    (cfgReq),
        .cfg_we_i     (cfgWe),
        .cfg_addr_i   (cfgAddr),
        .cfg_wdata_i  (cfgWdata),
        .cfg_gnt_o    (cfgGnt),
        .cfg_rvalid_o (cfgRvalid),
        .cfg_rdata_o  (cfgRdata),
        .cfg_err_o    (cfgErr),
        .lk_valid_i   (lkValid),
        .lk_ready_o   (lkReady),
        .lk_addr_i    (lkAddr),
        .lk_type_i    (lkType),
        .rsp_valid_o  (rspValid),
        .rsp_ready_i  (rspReady),
        .rsp_hit_o    (rspHit),
        .rsp_rule_o   (rspRule),
        .rsp_cached_o (rspCached),
        .rsp_nonidem_o(rspNonidem),
        .rsp_fault_o  (rspFault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exhausted, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Lookup responses are compared as {hit, rule[3:0], cached, nonidem, fault}.
    always @(negedge clk) begin
        if (rstN) begin
            if (rspValid) begin
                if (lkQ.size() == 0) begin
                    checkOutput("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    checkOutput(lkQ[0].name,
                                64'({rspHit, rspRule, rspCached, rspNonidem, rspFault}),
                                64'({lkQ[0].hit, lkQ[0].rule, lkQ[0].cached, lkQ[0].nonidem, lkQ[0].fault}));
                    if (rspReady) void'(lkQ.pop_front());
                end
            end
            if (cfgRvalid) begin
                if (cfgQ.size() == 0) begin
                    checkOutput("cfg_unexpected", 64'd1, 64'd0);
                end else begin
                    checkOutput({cfgQ[0].name, "_err"}, 64'(cfgErr), 64'(cfgQ[0].err));
                    checkOutput({cfgQ[0].name, "_rdata"}, cfgRdata, cfgQ[0].rdata);
                    void'(cfgQ.pop_front());
                end
            end
        end
    end

    task automatic applyStimulus(input string name, input logic [63:0] addr, input logic [1:0] typ,
                                 input logic hit, input logic [3:0] rule, input logic cached,
                                 input logic nonidem, input logic fault);
        LkExp e;
        int   guard;
        e.name = name; e.hit = hit; e.rule = rule;
        e.cached = cached; e.nonidem = nonidem; e.fault = fault;
        lkQ.push_back(e);
        lkValid = 1'b1;
        lkAddr  = addr;
        lkType  = typ;
        guard   = 0;
        forever begin
            @(negedge clk);
            if (lkReady) break;
            guard++;
            if (guard > 50) begin
                checkOutput({name, "_accept_timeout"}, 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1 lkValid = 1'b0;
    endtask

    task automatic cfgAccess(input string name, input logic we, input logic [11:0] addr,
                             input logic [63:0] wdata, input logic expErr, input logic [63:0] expRdata);
        CfgExp e;
        e.name = name; e.err = expErr; e.rdata = expRdata;
        cfgQ.push_back(e);
        cfgReq   = 1'b1;
        cfgWe    = we;
        cfgAddr  = addr;
        cfgWdata = wdata;
        @(negedge clk);
        checkOutput({name, "_gnt"}, 64'(cfgGnt), 64'd1);
        @(posedge clk);
        #1 cfgReq = 1'b0;
        cfgWe = 1'b0;
    endtask

    initial begin
        rstN = 1'b0; cfgReq = 1'b0; cfgWe = 1'b0; cfgAddr = '0; cfgWdata = '0;
        lkValid = 1'b0; lkAddr = '0; lkType = Load; rspReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_lk_ready", 64'(lkReady), 64'd1);
        checkOutput("reset_rsp_valid", 64'(rspValid), 64'd0);
        checkOutput("reset_rsp_fields", 64'({rspHit, rspRule, rspCached, rspNonidem, rspFault}), 64'd0);
        checkOutput("reset_cfg_rvalid", 64'(cfgRvalid), 64'd0);
        checkOutput("reset_cfg_err", 64'(cfgErr), 64'd0);
        checkOutput("reset_cfg_rdata", cfgRdata, 64'd0);
        checkOutput("reset_cfg_gnt", 64'(cfgGnt), 64'd0);
        rstN = 1'b1;

        applyStimulus("empty_load", 64'h8000_0000, Load, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        cfgAccess("r0_base", 1'b1, 12'h000, 64'h8000_0000, 1'b0, 64'd0);
        cfgAccess("r0_len", 1'b1, 12'h008, 64'h1000_0000, 1'b0, 64'd0);
        cfgAccess("r0_attr", 1'b1, 12'h010, 64'h6, 1'b0, 64'd0);
        applyStimulus("r0_last", 64'h8FFF_FFF8, Load, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus("r0_end", 64'h9000_0000, Load, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus("r0_below", 64'h7FFF_FFFF, Load, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus("r0_fetch_ok", 64'h8000_0000, Fetch, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus("r0_rsvd", 64'h8000_0000, Rsvd, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);

        cfgAccess("r1_base", 1'b1, 12'h020, 64'h2000_0000, 1'b0, 64'd0);
        cfgAccess("r1_len", 1'b1, 12'h028, 64'h1000, 1'b0, 64'd0);
        cfgAccess("r1_attr", 1'b1, 12'h030, 64'h7FFF_FFF1, 1'b0, 64'd0);
        cfgAccess("r1_attr_rd", 1'b0, 12'h030, 64'd0, 1'b0, 64'h1);
        cfgAccess("r1_len_rd", 1'b0, 12'h028, 64'd0, 1'b0, 64'h1000);
        applyStimulus("r1_fetch", 64'h2000_0010, Fetch, 1'b1, 4'd1, 1'b0, 1'b1, 1'b1);
        applyStimulus("r1_store", 64'h2000_0FFF, Store, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
        applyStimulus("miss_fetch", 64'h0, Fetch, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

        cfgAccess("r2_base", 1'b1, 12'h040, 64'h8000_0000, 1'b0, 64'd0);
        cfgAccess("r2_len", 1'b1, 12'h048, 64'h200, 1'b0, 64'd0);
        cfgAccess("r2_attr", 1'b1, 12'h050, 64'h4, 1'b0, 64'd0);
        applyStimulus("overlap", 64'h8000_0100, Load, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);

        cfgAccess("r3_base", 1'b1, 12'h060, 64'hFFFF_FFFF_FFFF_F000, 1'b0, 64'd0);
        cfgAccess("r3_len", 1'b1, 12'h068, 64'h2000, 1'b0, 64'd0);
        cfgAccess("r3_attr", 1'b1, 12'h070, 64'h4, 1'b0, 64'd0);
        applyStimulus("wrap_top", 64'hFFFF_FFFF_FFFF_FFFF, Fetch, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus("wrap_zero", 64'h0, Load, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        cfgAccess("lock_set", 1'b1, 12'h010, 64'h8000_0006, 1'b0, 64'd0);
        cfgAccess("lock_base_wr", 1'b1, 12'h000, 64'h1234, 1'b1, 64'd0);
        cfgAccess("lock_base_rd", 1'b0, 12'h000, 64'd0, 1'b0, 64'h8000_0000);
        cfgAccess("lock_attr_wr", 1'b1, 12'h010, 64'h0, 1'b1, 64'd0);
        cfgAccess("lock_attr_rd", 1'b0, 12'h010, 64'd0, 1'b0, 64'h8000_0006);
        applyStimulus("lock_lookup", 64'h8000_0100, Load, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);

        cfgAccess("err_misalign", 1'b0, 12'h004, 64'd0, 1'b1, 64'd0);
        cfgAccess("err_off18", 1'b0, 12'h018, 64'd0, 1'b1, 64'd0);
        cfgAccess("err_range", 1'b0, 12'h120, 64'd0, 1'b1, 64'd0);
        cfgAccess("err_range_wr", 1'b1, 12'h3F8, 64'h5, 1'b1, 64'd0);

        cfgAccess("r4_base", 1'b1, 12'h080, 64'h4000_0000, 1'b0, 64'd0);
        cfgAccess("r4_attr", 1'b1, 12'h090, 64'h6, 1'b0, 64'd0);
        fork
            cfgAccess("r4_len", 1'b1, 12'h088, 64'h100, 1'b0, 64'd0);
            applyStimulus("same_cycle_old", 64'h4000_0000, Load, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        join
        applyStimulus("same_cycle_new", 64'h4000_0000, Load, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        applyStimulus("r4_end", 64'h4000_0100, Load, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        rspReady = 1'b0;
        fork
            begin
                applyStimulus("stall_a", 64'h8000_0000, Load, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
                applyStimulus("stall_b", 64'h2000_0010, Store, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
                applyStimulus("stall_c", 64'h9000_0000, Load, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            end
            begin
                @(posedge clk);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("stall_lk_ready", 64'(lkReady), 64'd0);
                end
                @(posedge clk);
                #2 rspReady = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;

        rspReady = 1'b0;
        applyStimulus("pending_drop", 64'h8000_0100, Load, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        rstN = 1'b0;
        lkQ.delete();
        cfgQ.delete();
        #1;
        checkOutput("midreset_rsp_valid", 64'(rspValid), 64'd0);
        checkOutput("midreset_lk_ready", 64'(lkReady), 64'd1);
        @(posedge clk);
        #1 rstN = 1'b1;
        rspReady = 1'b1;
        applyStimulus("cleared_table", 64'h8000_0100, Load, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        cfgAccess("cleared_attr_rd", 1'b0, 12'h010, 64'd0, 1'b0, 64'd0);
        cfgAccess("unlocked_base_wr", 1'b1, 12'h000, 64'h1000, 1'b0, 64'd0);

`ifdef PMA_VIOLATION_LOG_EN
        applyStimulus("log_fault1", 64'h100, Fetch, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus("log_fault2", 64'h200, Fetch, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        cfgAccess("log_addr_rd", 1'b0, 12'h100, 64'd0, 1'b0, 64'h100);
        cfgAccess("log_info_rd", 1'b0, 12'h108, 64'd0, 1'b0, 64'h8000_0020);
        cfgAccess("log_clear", 1'b1, 12'h108, 64'h0, 1'b0, 64'd0);
        cfgAccess("log_info_clr", 1'b0, 12'h108, 64'd0, 1'b0, 64'h0);
        applyStimulus("log_fault3", 64'h300, Fetch, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        cfgAccess("log_addr_rd2", 1'b0, 12'h100, 64'd0, 1'b0, 64'h300);
`else
        cfgAccess("nolog_addr_rd", 1'b0, 12'h100, 64'd0, 1'b1, 64'd0);
        cfgAccess("nolog_info_wr", 1'b1, 12'h108, 64'h0, 1'b1, 64'd0);
`endif

        repeat (4) @(posedge clk);
        #1;
        checkOutput("lk_queue_drained", 64'(lkQ.size()), 64'd0);
        checkOutput("cfg_queue_drained", 64'(cfgQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
